muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer_pkg.sv | 22 ++
 rtl/muldiv_sequencer_if.sv | 35 +++
 rtl/muldiv_sequencer_cycle_counter.sv | 27 ++
 rtl/muldiv_sequencer.sv | 148 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - shared state encoding and op/mux constants for the mult/div sequencer
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_MULT,
        WAIT_DIV,
        COMMIT,
        EXC
    } state_t;

    localparam logic OP_MULT       = 1'b0;
    localparam logic OP_DIV        = 1'b1;
    localparam logic HILO_SEL_MULT = 1'b0;
    localparam logic HILO_SEL_DIV  = 1'b1;

    function automatic logic hilo_sel_for(input logic op);
        return (op == OP_DIV) ? HILO_SEL_DIV : HILO_SEL_MULT;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - request, unit handshake and HI/LO control bundle for the sequencer
interface muldiv_sequencer_if;

    logic req_valid;
    logic req_op;
    logic req_ready;
    logic mult_start;
    logic mult_done;
    logic div_start;
    logic div_done;
    logic div_zero;
    logic hi_sel;
    logic lo_sel;
    logic hi_write;
    logic lo_write;
    logic hilo_read;
    logic stall;
    logic busy;
    logic op_done;
    logic div_zero_exc;
    logic timeout_exc;

    modport master (
        output req_valid, req_op, mult_done, div_done, div_zero, hilo_read,
        input  req_ready, mult_start, div_start, hi_sel, lo_sel, hi_write, lo_write,
               stall, busy, op_done, div_zero_exc, timeout_exc
    );

    modport slave (
        input  req_valid, req_op, mult_done, div_done, div_zero, hilo_read,
        output req_ready, mult_start, div_start, hi_sel, lo_sel, hi_write, lo_write,
               stall, busy, op_done, div_zero_exc, timeout_exc
    );

endinterface

// File: rtl/muldiv_sequencer_cycle_counter.sv
// rtl/muldiv_sequencer_cycle_counter.sv - clearable enabled cycle counter with terminal-count compare
module muldiv_cycle_counter #(
    parameter int W = 7
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - sequences mult/div units and commits HI/LO; watchdog under MULDIV_TIMEOUT_EN
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int START_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic                clock,
    input  logic                reset,
    muldiv_sequencer_if.slave   bus
);

    localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LIM   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic             op_q;
    logic             mult_start_q;
    logic             div_start_q;
    logic             write_q;
    logic             op_done_q;
    logic             div_zero_q;
    logic             busy;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_limit;
`ifdef MULDIV_TIMEOUT_EN
    logic             timeout_q;
`endif

    // One counter serves both the START hold and the WAIT watchdog; it restarts on each phase entry.
    always_comb begin
        cnt_clr   = (state == IDLE) || ((state == START) && cnt_tc);
        cnt_en    = (state == START);
`ifdef MULDIV_TIMEOUT_EN
        if ((state == WAIT_MULT) || (state == WAIT_DIV)) begin
            cnt_en = 1'b1;
        end
`endif
        cnt_limit = (state == START) ? START_LIM : TMO_LIM;
    end

    muldiv_cycle_counter #(
        .W (CNT_W)
    ) u_counter (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (cnt_limit),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op_q         <= OP_MULT;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            write_q      <= 1'b0;
            op_done_q    <= 1'b0;
            div_zero_q   <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
        end else begin
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            write_q      <= 1'b0;
            op_done_q    <= 1'b0;
            div_zero_q   <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q         <= bus.req_op;
                        state        <= START;
                        mult_start_q <= (bus.req_op == OP_MULT);
                        div_start_q  <= (bus.req_op == OP_DIV);
                    end
                end
                START: begin
                    if (cnt_tc) begin
                        state <= (op_q == OP_DIV) ? WAIT_DIV : WAIT_MULT;
                    end else begin
                        mult_start_q <= (op_q == OP_MULT);
                        div_start_q  <= (op_q == OP_DIV);
                    end
                end
                WAIT_MULT: begin
                    if (bus.mult_done) begin
                        state     <= COMMIT;
                        write_q   <= 1'b1;
                        op_done_q <= 1'b1;
                    end
`ifdef MULDIV_TIMEOUT_EN
                    else if (cnt_tc) begin
                        state     <= IDLE;
                        timeout_q <= 1'b1;
                    end
`endif
                end
                WAIT_DIV: begin
                    if (bus.div_zero) begin
                        state      <= EXC;
                        div_zero_q <= 1'b1;
                    end else if (bus.div_done) begin
                        state     <= COMMIT;
                        write_q   <= 1'b1;
                        op_done_q <= 1'b1;
                    end
`ifdef MULDIV_TIMEOUT_EN
                    else if (cnt_tc) begin
                        state     <= IDLE;
                        timeout_q <= 1'b1;
                    end
`endif
                end
                COMMIT:  state <= IDLE;
                EXC:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy             = (state != IDLE);
    assign bus.busy         = busy;
    assign bus.req_ready    = ~busy;
    assign bus.stall        = busy && (bus.hilo_read || bus.req_valid);
    assign bus.mult_start   = mult_start_q;
    assign bus.div_start    = div_start_q;
    assign bus.hi_sel       = hilo_sel_for(op_q);
    assign bus.lo_sel       = hilo_sel_for(op_q);
    assign bus.hi_write     = write_q;
    assign bus.lo_write     = write_q;
    assign bus.op_done      = op_done_q;
    assign bus.div_zero_exc = div_zero_q;
`ifdef MULDIV_TIMEOUT_EN
    assign bus.timeout_exc  = timeout_q;
`else
    assign bus.timeout_exc  = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed vectors plus a cycle-offset transaction model for muldiv_sequencer
module tb_muldiv_sequencer;

    localparam int S = 1;
`ifdef MULDIV_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic clock;
    logic reset;
    int   tests;
    int   fails;

    muldiv_sequencer_if bus ();

    muldiv_sequencer #(
        .START_CYCLES   (S),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (7)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Model: m_t counts cycles since acceptance (1..S = start strobe, then waiting);
    // m_res marks the single result cycle (1 = commit, 2 = divide-by-zero).
    bit m_busy;
    bit m_op;
    int m_t;
    int m_res;
    bit m_tmo;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_op   <= 1'b0;
            m_t    <= 0;
            m_res  <= 0;
            m_tmo  <= 1'b0;
        end else begin
            m_tmo <= 1'b0;
            if (!m_busy) begin
                if (bus.req_valid) begin
                    m_busy <= 1'b1;
                    m_op   <= bus.req_op;
                    m_t    <= 1;
                    m_res  <= 0;
                end
            end else if (m_res != 0) begin
                m_busy <= 1'b0;
                m_res  <= 0;
            end else begin
                if (m_t > S) begin
                    if (!m_op && bus.mult_done) m_res <= 1;
                    else if (m_op && bus.div_zero) m_res <= 2;
                    else if (m_op && bus.div_done) m_res <= 1;
`ifdef MULDIV_TIMEOUT_EN
                    else if (m_t - S == TMO) begin
                        m_busy <= 1'b0;
                        m_tmo  <= 1'b1;
                    end
`endif
                end
                m_t <= m_t + 1;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("m_req_ready", bus.req_ready, !m_busy);
            chk("m_busy", bus.busy, m_busy);
            chk("m_mult_start", bus.mult_start, m_busy && m_res == 0 && m_t <= S && !m_op);
            chk("m_div_start", bus.div_start, m_busy && m_res == 0 && m_t <= S && m_op);
            chk("m_hi_write", bus.hi_write, m_res == 1);
            chk("m_lo_write", bus.lo_write, m_res == 1);
            chk("m_op_done", bus.op_done, m_res == 1);
            chk("m_div_zero_exc", bus.div_zero_exc, m_res == 2);
            chk("m_hi_sel", bus.hi_sel, m_op);
            chk("m_lo_sel", bus.lo_sel, m_op);
            chk("m_stall", bus.stall, m_busy && (bus.hilo_read || bus.req_valid));
            chk("m_timeout_exc", bus.timeout_exc, m_tmo);
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 1'b0;
        bus.mult_done = 1'b0;
        bus.div_done  = 1'b0;
        bus.div_zero  = 1'b0;
        bus.hilo_read = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mult_start", bus.mult_start, 0);
        chk("rst_hi_write", bus.hi_write, 0);
        reset = 1'b0;
        tick();

        // MULT, done at cycle 5
        bus.req_valid = 1'b1; bus.req_op = 1'b0;
        tick(); bus.req_valid = 1'b0;
        chk("t1_mult_start_c1", bus.mult_start, 1);
        chk("t1_div_start_c1", bus.div_start, 0);
        tick();
        chk("t1_mult_start_c2", bus.mult_start, 0);
        chk("t1_busy_c2", bus.busy, 1);
        repeat (3) tick();
        bus.mult_done = 1'b1;
        tick(); bus.mult_done = 1'b0;
        chk("t1_hi_write_c6", bus.hi_write, 1);
        chk("t1_lo_write_c6", bus.lo_write, 1);
        chk("t1_hi_sel_c6", bus.hi_sel, 0);
        chk("t1_op_done_c6", bus.op_done, 1);
        tick();
        chk("t1_busy_c7", bus.busy, 0);

        // DIV normal, done at cycle 34
        bus.req_valid = 1'b1; bus.req_op = 1'b1;
        tick(); bus.req_valid = 1'b0;
        chk("t2_div_start_c1", bus.div_start, 1);
        repeat (33) tick();
        bus.div_done = 1'b1;
        tick(); bus.div_done = 1'b0;
        chk("t2_hi_sel_c35", bus.hi_sel, 1);
        chk("t2_lo_sel_c35", bus.lo_sel, 1);
        chk("t2_hi_write_c35", bus.hi_write, 1);
        chk("t2_div_zero_exc_c35", bus.div_zero_exc, 0);
        tick();

        // DIV by zero with simultaneous done
        bus.req_valid = 1'b1; bus.req_op = 1'b1;
        tick(); bus.req_valid = 1'b0;
        repeat (2) tick();
        bus.div_zero = 1'b1; bus.div_done = 1'b1;
        tick(); bus.div_zero = 1'b0; bus.div_done = 1'b0;
        chk("t3_div_zero_exc", bus.div_zero_exc, 1);
        chk("t3_hi_write", bus.hi_write, 0);
        chk("t3_op_done", bus.op_done, 0);
        tick();
        chk("t3_req_ready", bus.req_ready, 1);
        chk("t3_exc_cleared", bus.div_zero_exc, 0);

        // Interlock: hilo_read during MULT, second request held through busy
        bus.req_valid = 1'b1; bus.req_op = 1'b0; bus.hilo_read = 1'b1;
        tick(); bus.req_op = 1'b1;
        chk("t4_stall_c1", bus.stall, 1);
        repeat (2) tick();
        chk("t4_stall_c3", bus.stall, 1);
        chk("t4_req_ready_c3", bus.req_ready, 0);
        tick();
        bus.mult_done = 1'b1;
        tick(); bus.mult_done = 1'b0;
        chk("t4_op_done_c5", bus.op_done, 1);
        chk("t4_stall_c5", bus.stall, 1);
        tick();
        chk("t4_stall_c6", bus.stall, 0);
        chk("t4_req_ready_c6", bus.req_ready, 1);
        tick(); bus.req_valid = 1'b0; bus.hilo_read = 1'b0;
        chk("t4_div_start_c7", bus.div_start, 1);
        chk("t4_busy_c7", bus.busy, 1);
        repeat (2) tick();
        bus.div_done = 1'b1;
        tick(); bus.div_done = 1'b0;
        chk("t4_hi_sel_c10", bus.hi_sel, 1);
        chk("t4_hi_write_c10", bus.hi_write, 1);
        tick();

        // Asynchronous reset while in WAIT_DIV
        bus.req_valid = 1'b1; bus.req_op = 1'b1;
        tick(); bus.req_valid = 1'b0;
        repeat (2) tick();
        #3 reset = 1'b1;
        #1;
        chk("t5_busy_async", bus.busy, 0);
        chk("t5_req_ready_async", bus.req_ready, 1);
        chk("t5_hi_sel_async", bus.hi_sel, 0);
        repeat (2) tick();
        reset = 1'b0;
        bus.div_done = 1'b1;
        tick(); bus.div_done = 1'b0;
        chk("t5_hi_write_late_done", bus.hi_write, 0);
        chk("t5_op_done_late_done", bus.op_done, 0);
        chk("t5_busy_late_done", bus.busy, 0);
        tick();

`ifdef MULDIV_TIMEOUT_EN
        // Watchdog: no done, pulse 8 cycles after entering WAIT (cycle 10)
        bus.req_valid = 1'b1; bus.req_op = 1'b0;
        tick(); bus.req_valid = 1'b0;
        repeat (8) tick();
        chk("t6_timeout_c9", bus.timeout_exc, 0);
        chk("t6_busy_c9", bus.busy, 1);
        tick();
        chk("t6_timeout_c10", bus.timeout_exc, 1);
        chk("t6_hi_write_c10", bus.hi_write, 0);
        tick();
        chk("t6_timeout_c11", bus.timeout_exc, 0);
`else
        // No watchdog: WAIT holds indefinitely
        bus.req_valid = 1'b1; bus.req_op = 1'b0;
        tick(); bus.req_valid = 1'b0;
        repeat (20) tick();
        chk("t6_busy_c21", bus.busy, 1);
        chk("t6_timeout_c21", bus.timeout_exc, 0);
        bus.mult_done = 1'b1;
        tick(); bus.mult_done = 1'b0;
        chk("t6_op_done_c22", bus.op_done, 1);
        tick();
`endif
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
